// File: rtl/dsp_pkg.sv
// Shared constants, opmode codes and FSM state encoding for the DSP48 MAC sequencer.
// Optional feature macro: DSP_MAC_BIAS_EN (selects the C-bias first-tap opmode).
package dsp_pkg;

   localparam int DATA_W = 18;
   localparam int COEF_W = 18;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = 48;
   localparam int OPM_W  = 8;

   // Slice OPMODE: [1:0] X mux, [3:2] Z mux; upper nibble stays zero (no pre-adder, add, CIN=0).
   localparam logic [OPM_W-1:0] OP_FIRST      = 8'h01;
   localparam logic [OPM_W-1:0] OP_FIRST_BIAS = 8'h0D;
   localparam logic [OPM_W-1:0] OP_ACC        = 8'h09;
   localparam logic [OPM_W-1:0] OP_HOLD       = 8'h08;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   function automatic logic [OPM_W-1:0] first_opmode(input logic bias);
      return bias ? OP_FIRST_BIAS : OP_FIRST;
   endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand and result valid/ready streams of the MAC sequencer.
// slave: sequencer side; master: producer/consumer side.
interface dsp_mac_sequencer_if;
   import dsp_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_a;
   logic [COEF_W-1:0] s_b;

   logic              m_valid;
   logic              m_ready;
   logic [ACC_W-1:0]  m_data;

   modport slave (
      input  s_valid, s_a, s_b, m_ready,
      output s_ready, m_valid, m_data
   );

   modport master (
      output s_valid, s_a, s_b, m_ready,
      input  s_ready, m_valid, m_data
   );

endinterface

// File: rtl/dsp_mac_delay.sv
// Opmode shift line of parameterised depth; every stage resets to OP_HOLD so the
// slice sees only hold codes while the sequencer is in reset.
module dsp_mac_delay
   import dsp_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPM_W-1:0] i_op,
   output logic [OPM_W-1:0] o_op
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign o_op = i_op;
      end else begin : g_line
         logic [OPM_W-1:0] r_line [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) r_line[i] <= OP_HOLD;
            end else begin
               r_line[0] <= i_op;
               for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
            end
         end

         assign o_op = r_line[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Frame MAC controller feeding a DSP48 slice (A/B/OPMODE) and capturing its P output.
// Define DSP_MAC_BIAS_EN to add cfg_bias_en (first tap adds the slice C input).
module dsp_mac_sequencer
   import dsp_pkg::*;
#(
   parameter int LEN_W      = 8,
   parameter int OPMODE_LAG = 1,
   parameter int P_LAT      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEN_W-1:0]   cfg_len,
`ifdef DSP_MAC_BIAS_EN
   input  logic               cfg_bias_en,
`endif
   dsp_mac_sequencer_if.slave bus,
   output logic [DATA_W-1:0]  dsp_a,
   output logic [COEF_W-1:0]  dsp_b,
   output logic [OPM_W-1:0]   dsp_opmode,
   input  logic [ACC_W-1:0]   dsp_p,
   output logic               busy
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_HOLD  = HOLD;

   localparam int DCNT_W = (P_LAT < 1) ? 1 : $clog2(P_LAT + 1);

   logic [1:0]        r_state;
   logic              r_live;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_cnt;
   logic [DCNT_W-1:0] r_dcnt;
   logic              r_m_valid;
   logic [ACC_W-1:0]  r_m_data;

   logic [DATA_W-1:0] r_a_p0;
   logic [COEF_W-1:0] r_b_p0;
   logic [OPM_W-1:0]  r_op_p0;
   logic              r_vld_p0;

   logic              w_ready;
   logic              w_accept;
   logic              w_bias;
   logic [LEN_W-1:0]  w_len_eff;
   logic [OPM_W-1:0]  w_op_issue;

`ifdef DSP_MAC_BIAS_EN
   assign w_bias = cfg_bias_en;
`else
   assign w_bias = 1'b0;
`endif

   // r_live keeps s_ready low for the cycle after reset release as well as during reset.
   assign w_ready   = r_live && ((r_state == S_IDLE) || (r_state == S_RUN));
   assign w_accept  = bus.s_valid && w_ready;
   assign w_len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

   always_comb begin
      w_op_issue = OP_HOLD;
      if (w_accept) begin
         w_op_issue = (r_state == S_IDLE) ? first_opmode(w_bias) : OP_ACC;
      end
   end

   // ---- issue stage p0: operands and opmode for the slot seen by the slice next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_p0   <= '0;
         r_b_p0   <= '0;
         r_op_p0  <= OP_HOLD;
         r_vld_p0 <= 1'b0;
      end else begin
         r_a_p0   <= w_accept ? bus.s_a : '0;
         r_b_p0   <= w_accept ? bus.s_b : '0;
         r_op_p0  <= w_op_issue;
         r_vld_p0 <= w_accept;
      end
   end

   // ---- frame control: tap counting, drain timing, result hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_live    <= 1'b0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_dcnt    <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_len  <= w_len_eff;
                  r_cnt  <= LEN_W'(1);
                  r_dcnt <= '0;
                  r_state <= (w_len_eff == LEN_W'(1)) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (r_cnt == r_len - LEN_W'(1)) begin
                     r_dcnt  <= '0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // The last tap's sum first appears on P P_LAT cycles after its issue cycle.
               if (r_dcnt == DCNT_W'(P_LAT)) begin
                  r_m_data  <= dsp_p;
                  r_m_valid <= 1'b1;
                  r_state   <= S_HOLD;
               end else begin
                  r_dcnt <= r_dcnt + DCNT_W'(1);
               end
            end
            S_HOLD: begin
               if (r_m_valid && bus.m_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---- opmode stage p1..pN: align the code with the slice's OPMODE register
   dsp_mac_delay #(
      .DEPTH (OPMODE_LAG)
   ) u_opm_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_op  (r_op_p0),
      .o_op  (dsp_opmode)
   );

   assign dsp_a       = r_a_p0;
   assign dsp_b       = r_b_p0;
   assign bus.s_ready = w_ready;
   assign bus.m_valid = r_m_valid;
   assign bus.m_data  = r_m_data;
   assign busy        = (r_state != S_IDLE);

   // r_vld_p0 marks real taps in the issue stage; kept for slot tracing alongside data.
   logic w_vld_unused;
   assign w_vld_unused = r_vld_p0;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench: sequencer driving a behavioural DSP48 slice (A1/B1, M, OPMODE, P registers).
module tb_dsp_mac_sequencer;
   import dsp_pkg::*;

   localparam int LEN_W = 8;
   localparam int P_LAT = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              bias_en = 1'b0;
   logic [DATA_W-1:0] dsp_a;
   logic [COEF_W-1:0] dsp_b;
   logic [OPM_W-1:0]  dsp_opmode;
   logic [ACC_W-1:0]  dsp_p;
   logic              busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_acc = 0;

   dsp_mac_sequencer_if bus();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dsp_mac_sequencer #(
      .LEN_W      (LEN_W),
      .OPMODE_LAG (1),
      .P_LAT      (P_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_len     (cfg_len),
`ifdef DSP_MAC_BIAS_EN
      .cfg_bias_en (bias_en),
`endif
      .bus         (bus.slave),
      .dsp_a       (dsp_a),
      .dsp_b       (dsp_b),
      .dsp_opmode  (dsp_opmode),
      .dsp_p       (dsp_p),
      .busy        (busy)
   );

   // Behavioural slice: A1/B1 -> M -> P, OPMODE registered once; C is a constant bias.
   logic [DATA_W-1:0] sl_a1;
   logic [COEF_W-1:0] sl_b1;
   logic [PROD_W-1:0] sl_m;
   logic [OPM_W-1:0]  sl_op;
   logic [ACC_W-1:0]  sl_p, sl_x, sl_z;
   logic [ACC_W-1:0]  sl_c = 48'd100;

   always_comb begin
      sl_x = (sl_op[1:0] == 2'b01) ? {{(ACC_W-PROD_W){1'b0}}, sl_m} : '0;
      case (sl_op[3:2])
         2'b10:   sl_z = sl_p;
         2'b11:   sl_z = sl_c;
         default: sl_z = '0;
      endcase
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_op <= OP_HOLD; sl_p <= '0;
      end else begin
         sl_a1 <= dsp_a;
         sl_b1 <= dsp_b;
         sl_m  <= sl_a1 * sl_b1;
         sl_op <= dsp_opmode;
         sl_p  <= sl_z + sl_x;
      end
   end
   assign dsp_p = sl_p;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] a, input logic [COEF_W-1:0] b);
      int n = 0;
      bus.s_valid = 1'b1; bus.s_a = a; bus.s_b = b;
      while (!bus.s_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.s_ready) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      t_acc = cyc;
      bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
   endtask

   task automatic wait_result(input string tag, input logic [ACC_W-1:0] exp);
      int n = 0;
      while (!bus.m_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_lat"}, 64'(cyc - t_acc), 64'(1 + P_LAT));
      check({tag, "_data"}, 64'(bus.m_data), 64'(exp));
      check({tag, "_no_rdy"}, 64'(bus.s_ready), 64'd0);
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      check({tag, "_vld_clr"}, 64'(bus.m_valid), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_vld;
      bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.m_ready = 1'b0;

      // reset values
      repeat (3) @(posedge clk); #1;
      check("rst_s_ready", 64'(bus.s_ready), 64'd0);
      check("rst_dsp_a",   64'(dsp_a), 64'd0);
      check("rst_dsp_b",   64'(dsp_b), 64'd0);
      check("rst_opmode",  64'(dsp_opmode), 64'h08);
      check("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check("rst_m_data",  64'(bus.m_data), 64'd0);
      check("rst_busy",    64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_s_ready", 64'(bus.s_ready), 64'd1);

      // len=3 back-to-back: 2*5 + 3*6 + 4*7 = 56
      cfg_len = 8'd3;
      send(18'd2, 18'd5);
      check("bb_issue_a", 64'(dsp_a), 64'd2);
      check("bb_issue_b", 64'(dsp_b), 64'd5);
      check("bb_busy",    64'(busy), 64'd1);
      send(18'd3, 18'd6);
      check("bb_opm_first", 64'(dsp_opmode), 64'h01);
      send(18'd4, 18'd7);
      check("bb_opm_acc", 64'(dsp_opmode), 64'h09);
      wait_result("bb", 48'd56);

      // same frame with 2-cycle gaps
      send(18'd2, 18'd5);
      @(posedge clk); #1;
      check("gap_bubble_a", 64'(dsp_a), 64'd0);
      check("gap_opm_first", 64'(dsp_opmode), 64'h01);
      @(posedge clk); #1;
      check("gap_opm_hold", 64'(dsp_opmode), 64'h08);
      send(18'd3, 18'd6);
      repeat (2) begin @(posedge clk); #1; end
      send(18'd4, 18'd7);
      wait_result("gap", 48'd56);

`ifdef DSP_MAC_BIAS_EN
      // bias: C=100 + 3*4 = 112; without bias 12
      cfg_len = 8'd1;
      bias_en = 1'b1;
      send(18'd3, 18'd4);
      bias_en = 1'b0;
      wait_result("bias1", 48'd112);
      send(18'd3, 18'd4);
      wait_result("bias0", 48'd12);
`endif

      // cfg_len=0 treated as 1; m_ready held high gives a one-cycle pulse
      cfg_len = 8'd0;
      bus.m_ready = 1'b1;
      send(18'h3FFFF, 18'h3FFFF);
      wait_result("len0", 48'hF_FFF8_0001);

      // result held with m_ready low; cfg_len change mid-frame ignored; 1 + 63 = 64
      cfg_len = 8'd2;
      send(18'd1, 18'd1);
      cfg_len = 8'd5;
      send(18'd7, 18'd9);
      cfg_len = 8'd1;
      bus.s_valid = 1'b1; bus.s_a = 18'd5; bus.s_b = 18'd5;
      begin
         int n = 0;
         while (!bus.m_valid && n < 40) begin @(posedge clk); #1; n++; end
      end
      check("hold_lat", 64'(cyc - t_acc), 64'(1 + P_LAT));
      for (int i = 0; i < 5; i++) begin
         check("hold_s_ready", 64'(bus.s_ready), 64'd0);
         check("hold_m_data",  64'(bus.m_data), 64'd64);
         check("hold_m_valid", 64'(bus.m_valid), 64'd1);
         @(posedge clk); #1;
      end
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      check("hold_exit_vld", 64'(bus.m_valid), 64'd0);
      check("hold_exit_rdy", 64'(bus.s_ready), 64'd1);
      send(18'd5, 18'd5);
      wait_result("after_hold", 48'd25);

      // reset after the 2nd tap of a len=4 frame
      cfg_len = 8'd4;
      send(18'd1, 18'd1);
      send(18'd2, 18'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
      check("mid_rst_opmode",  64'(dsp_opmode), 64'h08);
      check("mid_rst_busy",    64'(busy), 64'd0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      saw_vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.m_valid) saw_vld = 1'b1;
      end
      check("mid_rst_no_vld", 64'(saw_vld), 64'd0);
      check("mid_rst_opm_idle", 64'(dsp_opmode), 64'h08);
      cfg_len = 8'd1;
      send(18'd2, 18'd2);
      wait_result("post_rst", 48'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
